mer_stats_accum: RTL

//  Downstream of the MER test harness. Over fixed windows of symbols, accumulates
//  the slicer error power and the mean decision-variable magnitude, and counts

---
 rtl/mer_stats_accum.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mer_stats_accum.sv
// mer_stats_accum
//   Windowed statistics for the MER test harness. Over windows of N = 2**LOG2_N
//   symbols it averages |decision_var| (fed back to the slicer as ref_level) and
//   error^2 (err_power, Q1.17, to the MER readout), and counts mis-decided
//   symbols. Windows are aligned to the LFSR clear_accum strobe.
//
//   Build option: define MER_SYM_ERR_COUNT_EN to implement the symbol-error
//   counter. Without it there is no err_cnt register, sym_err_count reads 0 and
//   sym_error is ignored.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   sym_clk_en     in   symbol-rate enable; state advances only when high
//   clear_accum    in   window-align strobe, sampled with sym_clk_en
//   decision_var   in   signed Q1.17 slicer input
//   error          in   signed Q1.17 slicer error
//   sym_error      in   1 = current symbol mis-decided
//   ref_level      out  mean |decision_var| of the last complete window
//   err_power      out  mean error^2 (unsigned Q1.17) of the last complete window
//   sym_err_count  out  symbol errors in the last complete window
//   stats_valid    out  one-clk pulse when the outputs update
module mer_stats_accum #(
  parameter int unsigned        LOG2_N   = 4,
  parameter logic signed [17:0] REF_INIT = 18'sd87381
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_clk_en,
  input  logic               clear_accum,
  input  logic signed [17:0] decision_var,
  input  logic signed [17:0] error,
  input  logic               sym_error,
  output logic signed [17:0] ref_level,
  output logic [17:0]        err_power,
  output logic [LOG2_N:0]    sym_err_count,
  output logic               stats_valid
);

  localparam int unsigned        AccW    = 18 + LOG2_N;
  localparam logic [LOG2_N-1:0]  LastSym = '1;
  localparam logic [LOG2_N-1:0]  CntOne  = {{(LOG2_N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StAccum, StDump} state_e;

  state_e            state_q;
  logic [AccW-1:0]   sum_abs_q;
  logic [AccW-1:0]   sum_sq_q;
  logic [LOG2_N-1:0] sym_cnt_q;

  // Per-symbol contributions. |-131072| = 131072 still fits as 18-bit unsigned.
  logic [17:0]        abs_dv;
  logic signed [35:0] err_sq_full;
  logic [17:0]        err_sq;
  logic [AccW-1:0]    abs_ext;
  logic [AccW-1:0]    sq_ext;

  assign abs_dv      = decision_var[17] ? $unsigned(-decision_var) : $unsigned(decision_var);
  assign err_sq_full = 36'(error) * 36'(error);
  // Square is non-negative and at most 2^34, so bit 35 is always 0.
  assign err_sq      = err_sq_full[34:17];
  assign abs_ext     = {{LOG2_N{1'b0}}, abs_dv};
  assign sq_ext      = {{LOG2_N{1'b0}}, err_sq};

  logic unused_sq_bits;
  assign unused_sq_bits = ^{err_sq_full[35], err_sq_full[16:0]};

  // Symbol-level strobes shared by the FSM and the optional error counter.
  //   acc_fresh : this symbol starts a new window (sums reload from it)
  //   acc_add   : this symbol is added to the running window
  //   win_close : the added symbol is the last of the window
  // A clear on the window-closing symbol does not restart: the window completes
  // and DUMP clears, so the symbol is counted exactly once.
  logic acc_fresh;
  logic acc_add;
  logic win_close;

  always_comb begin
    acc_fresh = 1'b0;
    acc_add   = 1'b0;
    if (sym_clk_en && clear_accum) begin
      if (state_q == StIdle) begin
        acc_fresh = 1'b1;
      end else if (state_q == StAccum && sym_cnt_q != LastSym) begin
        acc_fresh = 1'b1;
      end
    end
    if (sym_clk_en && state_q == StAccum && !acc_fresh) begin
      acc_add = 1'b1;
    end
    win_close = acc_add && (sym_cnt_q == LastSym);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sum_abs_q   <= '0;
      sum_sq_q    <= '0;
      sym_cnt_q   <= '0;
      ref_level   <= REF_INIT;
      err_power   <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (acc_fresh) begin
            sum_abs_q <= abs_ext;
            sum_sq_q  <= sq_ext;
            sym_cnt_q <= CntOne;
            state_q   <= StAccum;
          end
        end
        StAccum: begin
          if (acc_fresh) begin
            sum_abs_q <= abs_ext;
            sum_sq_q  <= sq_ext;
            sym_cnt_q <= CntOne;
          end else if (acc_add) begin
            sum_abs_q <= sum_abs_q + abs_ext;
            sum_sq_q  <= sum_sq_q + sq_ext;
            if (win_close) begin
              state_q <= StDump;
            end else begin
              sym_cnt_q <= sym_cnt_q + CntOne;
            end
          end
        end
        StDump: begin
          // Mean = sum / N, truncating. Any enable seen here is dropped.
          ref_level   <= sum_abs_q[LOG2_N +: 18];
          err_power   <= sum_sq_q[LOG2_N +: 18];
          stats_valid <= 1'b1;
          sum_abs_q   <= '0;
          sum_sq_q    <= '0;
          sym_cnt_q   <= '0;
          state_q     <= StAccum;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef MER_SYM_ERR_COUNT_EN
  logic [LOG2_N:0] err_cnt_q;
  logic [LOG2_N:0] err_inc;

  assign err_inc = {{LOG2_N{1'b0}}, sym_error};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q     <= '0;
      sym_err_count <= '0;
    end else if (acc_fresh) begin
      err_cnt_q <= err_inc;
    end else if (acc_add) begin
      err_cnt_q <= err_cnt_q + err_inc;
    end else if (state_q == StDump) begin
      sym_err_count <= err_cnt_q;
      err_cnt_q     <= '0;
    end
  end
`else
  logic unused_sym_error;
  assign unused_sym_error = sym_error;
  assign sym_err_count    = '0;
`endif

endmodule
